sram_axi_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the AXI-style SRAM/memory slave port: AR/R, AW/W/B with len/size/burst sidebands, 64-bit data.
- Sits between the instruction-fetch cache (M0) and the data cache (M1) and the single memory slave.
- Read and write channels are arbitrated independently. A grant is held for a whole burst: AR through the last R beat, AW through the B handshake.

---
 rtl/sram_arb_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 29 ++
 rtl/sram_axi_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_sram_axi_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the two-master SRAM/memory AXI arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    // M0 = instruction-fetch cache, M1 = data cache
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way picker. prio names the master that wins a tie in round-robin mode;
// it only moves when a burst completes, so a held grant never disturbs it.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       owner,
    input  logic       rr_en,
    output logic       grant
);

    logic prio;

    // after a completed burst the other master gets priority
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio <= M0;
        end else if (update) begin
            prio <= ~owner;
        end
    end

    // single requester always wins; a tie goes to prio, or to M1 when fixed
    assign grant = (req == 2'b11) ? (rr_en ? prio : M1) : req[1];

endmodule

// File: rtl/sram_axi_arbiter.sv
// Two-master to one-slave AXI arbiter for the memory port. Read and write
// channels are arbitrated independently; a grant is held for a full burst.
// Data phases are pure combinational routing gated by the FSM state.
module sram_axi_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int RR_EN  = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    // master 0
    input  logic                m0_ar_valid,
    input  logic [ADDR_W-1:0]   m0_ar_addr,
    input  logic [7:0]          m0_ar_len,
    input  logic [2:0]          m0_ar_size,
    input  logic [1:0]          m0_ar_burst,
    output logic                m0_ar_ready,
    output logic                m0_r_valid,
    output logic [DATA_W-1:0]   m0_r_data,
    output logic [1:0]          m0_r_resp,
    output logic                m0_r_last,
    input  logic                m0_r_ready,
    input  logic                m0_aw_valid,
    input  logic [ADDR_W-1:0]   m0_aw_addr,
    input  logic [7:0]          m0_aw_len,
    input  logic [2:0]          m0_aw_size,
    input  logic [1:0]          m0_aw_burst,
    output logic                m0_aw_ready,
    input  logic                m0_w_valid,
    input  logic [DATA_W-1:0]   m0_w_data,
    input  logic [DATA_W/8-1:0] m0_w_strb,
    output logic                m0_w_ready,
    output logic                m0_b_valid,
    output logic [1:0]          m0_b_resp,
    input  logic                m0_b_ready,
    // master 1
    input  logic                m1_ar_valid,
    input  logic [ADDR_W-1:0]   m1_ar_addr,
    input  logic [7:0]          m1_ar_len,
    input  logic [2:0]          m1_ar_size,
    input  logic [1:0]          m1_ar_burst,
    output logic                m1_ar_ready,
    output logic                m1_r_valid,
    output logic [DATA_W-1:0]   m1_r_data,
    output logic [1:0]          m1_r_resp,
    output logic                m1_r_last,
    input  logic                m1_r_ready,
    input  logic                m1_aw_valid,
    input  logic [ADDR_W-1:0]   m1_aw_addr,
    input  logic [7:0]          m1_aw_len,
    input  logic [2:0]          m1_aw_size,
    input  logic [1:0]          m1_aw_burst,
    output logic                m1_aw_ready,
    input  logic                m1_w_valid,
    input  logic [DATA_W-1:0]   m1_w_data,
    input  logic [DATA_W/8-1:0] m1_w_strb,
    output logic                m1_w_ready,
    output logic                m1_b_valid,
    output logic [1:0]          m1_b_resp,
    input  logic                m1_b_ready,
    // slave
    output logic                s_ar_valid,
    output logic [ADDR_W-1:0]   s_ar_addr,
    output logic [7:0]          s_ar_len,
    output logic [2:0]          s_ar_size,
    output logic [1:0]          s_ar_burst,
    input  logic                s_ar_ready,
    input  logic                s_r_valid,
    input  logic [DATA_W-1:0]   s_r_data,
    input  logic [1:0]          s_r_resp,
    input  logic                s_r_last,
    output logic                s_r_ready,
    output logic                s_aw_valid,
    output logic [ADDR_W-1:0]   s_aw_addr,
    output logic [7:0]          s_aw_len,
    output logic [2:0]          s_aw_size,
    output logic [1:0]          s_aw_burst,
    input  logic                s_aw_ready,
    output logic                s_w_valid,
    output logic [DATA_W-1:0]   s_w_data,
    output logic [DATA_W/8-1:0] s_w_strb,
    input  logic                s_w_ready,
    input  logic                s_b_valid,
    input  logic [1:0]          s_b_resp,
    output logic                s_b_ready
);

    localparam logic RR_BIT = (RR_EN != 0);

    rd_state_t  rd_state;
    logic       rd_owner;
    logic       rd_grant;
    logic       rd_addr_ph;
    logic       rd_data_ph;
    logic       rd_done;

    wr_state_t  wr_state;
    logic       wr_owner;
    logic       wr_grant;
    logic       wr_addr_ph;
    logic       wr_data_ph;
    logic       wr_resp_ph;
    logic       wr_done;
    logic [7:0] wlen;
    logic [7:0] wcnt;

    rr_arb2 u_rd_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({m1_ar_valid, m0_ar_valid}),
        .update  (rd_done),
        .owner   (rd_owner),
        .rr_en   (RR_BIT),
        .grant   (rd_grant)
    );

    rr_arb2 u_wr_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({m1_aw_valid, m0_aw_valid}),
        .update  (wr_done),
        .owner   (wr_owner),
        .rr_en   (RR_BIT),
        .grant   (wr_grant)
    );

    assign rd_addr_ph = (rd_state == R_ADDR);
    assign rd_data_ph = (rd_state == R_DATA);
    assign rd_done    = rd_data_ph && s_r_valid && s_r_ready && s_r_last;

    assign wr_addr_ph = (wr_state == W_ADDR);
    assign wr_data_ph = (wr_state == W_DATA);
    assign wr_resp_ph = (wr_state == W_RESP);
    assign wr_done    = wr_resp_ph && s_b_valid && s_b_ready;

    // read channel: arbitrate one cycle, forward AR, hold until the last R beat
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_state <= R_IDLE;
            rd_owner <= M0;
        end else begin
            case (rd_state)
                R_IDLE: if (m0_ar_valid || m1_ar_valid) begin
                    rd_owner <= rd_grant;
                    rd_state <= R_ADDR;
                end
                R_ADDR: if (s_ar_valid && s_ar_ready) rd_state <= R_DATA;
                R_DATA: if (rd_done) rd_state <= R_IDLE;
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // write channel: W only after AW, beats counted against the latched len
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_state <= W_IDLE;
            wr_owner <= M0;
            wlen     <= 8'd0;
            wcnt     <= 8'd0;
        end else begin
            case (wr_state)
                W_IDLE: if (m0_aw_valid || m1_aw_valid) begin
                    wr_owner <= wr_grant;
                    wr_state <= W_ADDR;
                end
                W_ADDR: if (s_aw_valid && s_aw_ready) begin
                    wlen     <= s_aw_len;
                    wcnt     <= 8'd0;
                    wr_state <= W_DATA;
                end
                W_DATA: if (s_w_valid && s_w_ready) begin
                    if (wcnt == wlen) begin
                        wr_state <= W_RESP;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                W_RESP: if (wr_done) wr_state <= W_IDLE;
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // AR forwarding from the owner's live request
    assign s_ar_valid  = rd_addr_ph && (rd_owner ? m1_ar_valid : m0_ar_valid);
    assign s_ar_addr   = rd_addr_ph ? (rd_owner ? m1_ar_addr  : m0_ar_addr)  : '0;
    assign s_ar_len    = rd_addr_ph ? (rd_owner ? m1_ar_len   : m0_ar_len)   : '0;
    assign s_ar_size   = rd_addr_ph ? (rd_owner ? m1_ar_size  : m0_ar_size)  : '0;
    assign s_ar_burst  = rd_addr_ph ? (rd_owner ? m1_ar_burst : m0_ar_burst) : '0;
    assign m0_ar_ready = rd_addr_ph && (rd_owner == M0) && s_ar_ready;
    assign m1_ar_ready = rd_addr_ph && (rd_owner == M1) && s_ar_ready;

    // R routing: payload broadcast, valid only to the owner
    assign s_r_ready  = rd_data_ph && (rd_owner ? m1_r_ready : m0_r_ready);
    assign m0_r_valid = rd_data_ph && (rd_owner == M0) && s_r_valid;
    assign m1_r_valid = rd_data_ph && (rd_owner == M1) && s_r_valid;
    assign m0_r_data  = rd_data_ph ? s_r_data : '0;
    assign m1_r_data  = rd_data_ph ? s_r_data : '0;
    assign m0_r_resp  = rd_data_ph ? s_r_resp : RESP_OKAY;
    assign m1_r_resp  = rd_data_ph ? s_r_resp : RESP_OKAY;
    assign m0_r_last  = rd_data_ph && s_r_last;
    assign m1_r_last  = rd_data_ph && s_r_last;

    // AW forwarding
    assign s_aw_valid  = wr_addr_ph && (wr_owner ? m1_aw_valid : m0_aw_valid);
    assign s_aw_addr   = wr_addr_ph ? (wr_owner ? m1_aw_addr  : m0_aw_addr)  : '0;
    assign s_aw_len    = wr_addr_ph ? (wr_owner ? m1_aw_len   : m0_aw_len)   : '0;
    assign s_aw_size   = wr_addr_ph ? (wr_owner ? m1_aw_size  : m0_aw_size)  : '0;
    assign s_aw_burst  = wr_addr_ph ? (wr_owner ? m1_aw_burst : m0_aw_burst) : '0;
    assign m0_aw_ready = wr_addr_ph && (wr_owner == M0) && s_aw_ready;
    assign m1_aw_ready = wr_addr_ph && (wr_owner == M1) && s_aw_ready;

    // W routing; beats beyond wlen see ready low because the state has left W_DATA
    assign s_w_valid  = wr_data_ph && (wr_owner ? m1_w_valid : m0_w_valid);
    assign s_w_data   = wr_data_ph ? (wr_owner ? m1_w_data : m0_w_data) : '0;
    assign s_w_strb   = wr_data_ph ? (wr_owner ? m1_w_strb : m0_w_strb) : '0;
    assign m0_w_ready = wr_data_ph && (wr_owner == M0) && s_w_ready;
    assign m1_w_ready = wr_data_ph && (wr_owner == M1) && s_w_ready;

    // B routing
    assign s_b_ready  = wr_resp_ph && (wr_owner ? m1_b_ready : m0_b_ready);
    assign m0_b_valid = wr_resp_ph && (wr_owner == M0) && s_b_valid;
    assign m1_b_valid = wr_resp_ph && (wr_owner == M1) && s_b_valid;
    assign m0_b_resp  = wr_resp_ph ? s_b_resp : RESP_OKAY;
    assign m1_b_resp  = wr_resp_ph ? s_b_resp : RESP_OKAY;

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Bench for sram_axi_arbiter: instance 0 is round-robin, instance 1 is fixed priority.
module tb_sram_axi_arbiter;
    import sram_arb_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [63:0] rq[$];
    logic [63:0] wq[$];
    logic [1:0]  bq[$];

    // master side, indexed [instance][master]
    logic        ar_valid [2][2];
    logic [63:0] ar_addr  [2][2];
    logic [7:0]  ar_len   [2][2];
    logic [2:0]  ar_size  [2][2];
    logic [1:0]  ar_burst [2][2];
    logic        r_ready  [2][2];
    logic        aw_valid [2][2];
    logic [63:0] aw_addr  [2][2];
    logic [7:0]  aw_len   [2][2];
    logic [2:0]  aw_size  [2][2];
    logic [1:0]  aw_burst [2][2];
    logic        w_valid  [2][2];
    logic [63:0] w_data   [2][2];
    logic [7:0]  w_strb   [2][2];
    logic        b_ready  [2][2];
    wire         ar_ready [2][2];
    wire         r_valid  [2][2];
    wire  [63:0] r_data   [2][2];
    wire  [1:0]  r_resp   [2][2];
    wire         r_last   [2][2];
    wire         aw_ready [2][2];
    wire         w_ready  [2][2];
    wire         b_valid  [2][2];
    wire  [1:0]  b_resp   [2][2];

    // slave side, indexed [instance]
    logic        s_ar_ready [2];
    logic        s_r_valid  [2];
    logic [63:0] s_r_data   [2];
    logic [1:0]  s_r_resp   [2];
    logic        s_r_last   [2];
    logic        s_aw_ready [2];
    logic        s_w_ready  [2];
    logic        s_b_valid  [2];
    logic [1:0]  s_b_resp   [2];
    wire         s_ar_valid [2];
    wire  [63:0] s_ar_addr  [2];
    wire  [7:0]  s_ar_len   [2];
    wire  [2:0]  s_ar_size  [2];
    wire  [1:0]  s_ar_burst [2];
    wire         s_r_ready  [2];
    wire         s_aw_valid [2];
    wire  [63:0] s_aw_addr  [2];
    wire  [7:0]  s_aw_len   [2];
    wire  [2:0]  s_aw_size  [2];
    wire  [1:0]  s_aw_burst [2];
    wire         s_w_valid  [2];
    wire  [63:0] s_w_data   [2];
    wire  [7:0]  s_w_strb   [2];
    wire         s_b_ready  [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        sram_axi_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(k == 0 ? 1 : 0)) u_dut (
            .clock(clock), .reset_n(reset_n),
            .m0_ar_valid(ar_valid[k][0]), .m0_ar_addr(ar_addr[k][0]), .m0_ar_len(ar_len[k][0]),
            .m0_ar_size(ar_size[k][0]), .m0_ar_burst(ar_burst[k][0]), .m0_ar_ready(ar_ready[k][0]),
            .m0_r_valid(r_valid[k][0]), .m0_r_data(r_data[k][0]), .m0_r_resp(r_resp[k][0]),
            .m0_r_last(r_last[k][0]), .m0_r_ready(r_ready[k][0]),
            .m0_aw_valid(aw_valid[k][0]), .m0_aw_addr(aw_addr[k][0]), .m0_aw_len(aw_len[k][0]),
            .m0_aw_size(aw_size[k][0]), .m0_aw_burst(aw_burst[k][0]), .m0_aw_ready(aw_ready[k][0]),
            .m0_w_valid(w_valid[k][0]), .m0_w_data(w_data[k][0]), .m0_w_strb(w_strb[k][0]),
            .m0_w_ready(w_ready[k][0]), .m0_b_valid(b_valid[k][0]), .m0_b_resp(b_resp[k][0]),
            .m0_b_ready(b_ready[k][0]),
            .m1_ar_valid(ar_valid[k][1]), .m1_ar_addr(ar_addr[k][1]), .m1_ar_len(ar_len[k][1]),
            .m1_ar_size(ar_size[k][1]), .m1_ar_burst(ar_burst[k][1]), .m1_ar_ready(ar_ready[k][1]),
            .m1_r_valid(r_valid[k][1]), .m1_r_data(r_data[k][1]), .m1_r_resp(r_resp[k][1]),
            .m1_r_last(r_last[k][1]), .m1_r_ready(r_ready[k][1]),
            .m1_aw_valid(aw_valid[k][1]), .m1_aw_addr(aw_addr[k][1]), .m1_aw_len(aw_len[k][1]),
            .m1_aw_size(aw_size[k][1]), .m1_aw_burst(aw_burst[k][1]), .m1_aw_ready(aw_ready[k][1]),
            .m1_w_valid(w_valid[k][1]), .m1_w_data(w_data[k][1]), .m1_w_strb(w_strb[k][1]),
            .m1_w_ready(w_ready[k][1]), .m1_b_valid(b_valid[k][1]), .m1_b_resp(b_resp[k][1]),
            .m1_b_ready(b_ready[k][1]),
            .s_ar_valid(s_ar_valid[k]), .s_ar_addr(s_ar_addr[k]), .s_ar_len(s_ar_len[k]),
            .s_ar_size(s_ar_size[k]), .s_ar_burst(s_ar_burst[k]), .s_ar_ready(s_ar_ready[k]),
            .s_r_valid(s_r_valid[k]), .s_r_data(s_r_data[k]), .s_r_resp(s_r_resp[k]),
            .s_r_last(s_r_last[k]), .s_r_ready(s_r_ready[k]),
            .s_aw_valid(s_aw_valid[k]), .s_aw_addr(s_aw_addr[k]), .s_aw_len(s_aw_len[k]),
            .s_aw_size(s_aw_size[k]), .s_aw_burst(s_aw_burst[k]), .s_aw_ready(s_aw_ready[k]),
            .s_w_valid(s_w_valid[k]), .s_w_data(s_w_data[k]), .s_w_strb(s_w_strb[k]),
            .s_w_ready(s_w_ready[k]),
            .s_b_valid(s_b_valid[k]), .s_b_resp(s_b_resp[k]), .s_b_ready(s_b_ready[k])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ar(input int k, input int m, input logic [63:0] addr, input logic [7:0] len);
        ar_valid[k][m] = 1'b1;
        ar_addr[k][m]  = addr;
        ar_len[k][m]   = len;
        ar_size[k][m]  = 3'd3;
        ar_burst[k][m] = 2'd1;
    endtask

    // AR of master m already driven; expect m to be granted and receive len+1 beats
    task automatic serve_read(input int k, input int m, input logic [63:0] addr, input logic [7:0] len,
                              input logic [63:0] seed, input logic [1:0] resp, output int waited);
        int n;
        logic [63:0] e;
        n = 0;
        s_ar_ready[k] = 1'b1;
        r_ready[k][m] = 1'b1;
        @(negedge clock);
        while (!s_ar_valid[k] && n < 20) begin
            @(negedge clock);
            n++;
        end
        waited = n;
        chk("rd_ar_bound", n < 20, 1);
        chk("rd_ar_addr", s_ar_addr[k], addr);
        chk("rd_ar_len", s_ar_len[k], len);
        chk("rd_ar_size", s_ar_size[k], 3);
        chk("rd_ar_ready_own", ar_ready[k][m], 1);
        chk("rd_ar_ready_oth", ar_ready[k][1-m], 0);
        @(posedge clock); #1;
        ar_valid[k][m] = 1'b0;
        s_ar_ready[k]  = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            s_r_valid[k] = 1'b1;
            s_r_data[k]  = seed + 64'(b);
            s_r_resp[k]  = resp;
            s_r_last[k]  = (b == int'(len));
            rq.push_back(seed + 64'(b));
            @(negedge clock);
            e = rq.pop_front();
            chk("rd_r_valid_own", r_valid[k][m], 1);
            chk("rd_r_valid_oth", r_valid[k][1-m], 0);
            chk("rd_s_r_ready", s_r_ready[k], 1);
            chk("rd_r_data", r_data[k][m], e);
            chk("rd_r_resp", r_resp[k][m], resp);
            chk("rd_r_last", r_last[k][m], (b == int'(len)));
            @(posedge clock); #1;
        end
        s_r_valid[k] = 1'b0;
        s_r_last[k]  = 1'b0;
    endtask

    // full write burst from master m with an optional W stall on the first beat
    task automatic serve_write(input int k, input int m, input logic [63:0] addr, input logic [7:0] len,
                               input logic [7:0] strb, input int stall, input logic [63:0] seed,
                               input logic [1:0] resp, output int waited);
        int n;
        logic [1:0] eb;
        n = 0;
        aw_valid[k][m] = 1'b1;
        aw_addr[k][m]  = addr;
        aw_len[k][m]   = len;
        aw_size[k][m]  = 3'd3;
        aw_burst[k][m] = 2'd1;
        w_valid[k][m]  = 1'b1;
        w_data[k][m]   = seed;
        w_strb[k][m]   = strb;
        b_ready[k][m]  = 1'b1;
        s_aw_ready[k]  = 1'b1;
        s_w_ready[k]   = 1'b1;
        @(negedge clock);
        while (!s_aw_valid[k] && n < 20) begin
            chk("wr_w_before_aw", s_w_valid[k], 0);
            @(negedge clock);
            n++;
        end
        waited = n;
        chk("wr_aw_bound", n < 20, 1);
        chk("wr_w_during_aw", s_w_valid[k], 0);
        chk("wr_aw_addr", s_aw_addr[k], addr);
        chk("wr_aw_len", s_aw_len[k], len);
        chk("wr_aw_ready_own", aw_ready[k][m], 1);
        chk("wr_aw_ready_oth", aw_ready[k][1-m], 0);
        @(posedge clock); #1;
        aw_valid[k][m] = 1'b0;
        s_aw_ready[k]  = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            w_data[k][m] = seed + 64'(b);
            wq.push_back(seed + 64'(b));
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    s_w_ready[k] = 1'b0;
                    @(negedge clock);
                    chk("wr_stall_ready", w_ready[k][m], 0);
                    chk("wr_stall_valid", s_w_valid[k], 1);
                    @(posedge clock); #1;
                end
            end
            s_w_ready[k] = 1'b1;
            @(negedge clock);
            chk("wr_s_w_valid", s_w_valid[k], 1);
            chk("wr_s_w_data", s_w_data[k], wq.pop_front());
            chk("wr_s_w_strb", s_w_strb[k], strb);
            chk("wr_w_ready_own", w_ready[k][m], 1);
            chk("wr_w_ready_oth", w_ready[k][1-m], 0);
            @(posedge clock); #1;
        end
        w_data[k][m] = seed + 64'(len) + 64'd1;
        @(negedge clock);
        chk("wr_excess_ready", w_ready[k][m], 0);
        chk("wr_excess_s_valid", s_w_valid[k], 0);
        @(posedge clock); #1;
        w_valid[k][m] = 1'b0;
        s_w_ready[k]  = 1'b0;
        s_b_valid[k]  = 1'b1;
        s_b_resp[k]   = resp;
        bq.push_back(resp);
        @(negedge clock);
        eb = bq.pop_front();
        chk("wr_b_valid_own", b_valid[k][m], 1);
        chk("wr_b_valid_oth", b_valid[k][1-m], 0);
        chk("wr_b_resp", b_resp[k][m], eb);
        chk("wr_s_b_ready", s_b_ready[k], 1);
        @(posedge clock); #1;
        s_b_valid[k] = 1'b0;
        b_ready[k][m] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        int wt2;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_ar_ready[k] = 0; s_r_valid[k] = 0; s_r_data[k] = 0; s_r_resp[k] = 0; s_r_last[k] = 0;
            s_aw_ready[k] = 0; s_w_ready[k] = 0; s_b_valid[k] = 0; s_b_resp[k] = 0;
            for (int m = 0; m < 2; m++) begin
                ar_valid[k][m] = 0; ar_addr[k][m] = 0; ar_len[k][m] = 0; ar_size[k][m] = 0;
                ar_burst[k][m] = 0; r_ready[k][m] = 0;
                aw_valid[k][m] = 0; aw_addr[k][m] = 0; aw_len[k][m] = 0; aw_size[k][m] = 0;
                aw_burst[k][m] = 0; w_valid[k][m] = 0; w_data[k][m] = 0; w_strb[k][m] = 0;
                b_ready[k][m] = 0;
            end
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            chk("rst_s_ar_valid", s_ar_valid[k], 0);
            chk("rst_s_aw_valid", s_aw_valid[k], 0);
            chk("rst_s_w_valid", s_w_valid[k], 0);
            chk("rst_s_r_ready", s_r_ready[k], 0);
            chk("rst_s_b_ready", s_b_ready[k], 0);
            chk("rst_s_ar_addr", s_ar_addr[k], 0);
            for (int m = 0; m < 2; m++) begin
                chk("rst_ar_ready", ar_ready[k][m], 0);
                chk("rst_r_valid", r_valid[k][m], 0);
                chk("rst_aw_ready", aw_ready[k][m], 0);
                chk("rst_w_ready", w_ready[k][m], 0);
                chk("rst_b_valid", b_valid[k][m], 0);
            end
        end
        @(posedge clock); #1;
        reset_n = 1'b1;

        // single M0 read: one arbitration cycle with no ready, then 4 beats
        set_ar(0, 0, 64'h8000_0000, 8'd3);
        @(negedge clock);
        chk("t1_idle_s_ar_valid", s_ar_valid[0], 0);
        chk("t1_idle_ar_ready", ar_ready[0][0], 0);
        @(posedge clock); #1;
        serve_read(0, 0, 64'h8000_0000, 8'd3, 64'hA000_0000, RESP_OKAY, wt);
        chk("t1_ar_latency", wt, 0);

        // M1 alone so the read pointer returns to M0
        set_ar(0, 1, 64'h1000, 8'd0);
        serve_read(0, 1, 64'h1000, 8'd0, 64'hB000, RESP_EXOKAY, wt);

        // round-robin collision with pointer at M0: M0 first, then M1
        set_ar(0, 0, 64'h2000, 8'd1);
        set_ar(0, 1, 64'h3000, 8'd1);
        serve_read(0, 0, 64'h2000, 8'd1, 64'hC000, RESP_OKAY, wt);
        serve_read(0, 1, 64'h3000, 8'd1, 64'hC100, RESP_OKAY, wt);
        chk("t2_m1_next_idle", wt, 1);

        // M0 wins alone, then a repeat collision goes to M1 first
        set_ar(0, 0, 64'h4000, 8'd0);
        serve_read(0, 0, 64'h4000, 8'd0, 64'hD000, RESP_OKAY, wt);
        set_ar(0, 0, 64'h5000, 8'd1);
        set_ar(0, 1, 64'h6000, 8'd1);
        serve_read(0, 1, 64'h6000, 8'd1, 64'hD100, RESP_OKAY, wt);
        serve_read(0, 0, 64'h5000, 8'd1, 64'hD200, RESP_OKAY, wt);

        // fixed priority instance: M1 wins both collisions
        for (int rep = 0; rep < 2; rep++) begin
            set_ar(1, 0, 64'h7000 + 64'(rep), 8'd1);
            set_ar(1, 1, 64'h7800 + 64'(rep), 8'd1);
            serve_read(1, 1, 64'h7800 + 64'(rep), 8'd1, 64'hE000, RESP_OKAY, wt);
            serve_read(1, 0, 64'h7000 + 64'(rep), 8'd1, 64'hE100, RESP_OKAY, wt);
        end

        // M1 write, len=1, W stalled for 2 cycles, third beat refused, B only to M1
        serve_write(0, 1, 64'h9000, 8'd1, 8'h0F, 2, 64'hF000, RESP_OKAY, wt);

        // concurrent M0 read and M1 write run on independent channels
        set_ar(0, 0, 64'hA100, 8'd3);
        fork
            serve_read(0, 0, 64'hA100, 8'd3, 64'h1_0000, RESP_OKAY, wt);
            serve_write(0, 1, 64'hA200, 8'd2, 8'hFF, 0, 64'h2_0000, RESP_SLVERR, wt2);
        join
        chk("t5_rd_indep", wt, 1);
        chk("t5_wr_indep", wt2, 1);

        // reset in the middle of the second of four R beats
        set_ar(0, 0, 64'hB100, 8'd3);
        s_ar_ready[0] = 1'b1;
        r_ready[0][0] = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        ar_valid[0][0] = 1'b0;
        s_ar_ready[0]  = 1'b0;
        s_r_valid[0] = 1'b1;
        s_r_data[0]  = 64'h55;
        @(negedge clock);
        chk("t6_beat1_valid", r_valid[0][0], 1);
        @(posedge clock); #1;
        s_r_data[0] = 64'h56;
        @(negedge clock);
        chk("t6_beat2_valid", r_valid[0][0], 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_r_valid0", r_valid[0][0], 0);
        chk("t6_rst_r_valid1", r_valid[0][1], 0);
        chk("t6_rst_r_data", r_data[0][0], 0);
        chk("t6_rst_s_r_ready", s_r_ready[0], 0);
        chk("t6_rst_s_ar_valid", s_ar_valid[0], 0);
        s_r_valid[0] = 1'b0;
        r_ready[0][0] = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        set_ar(0, 1, 64'hC100, 8'd1);
        serve_read(0, 1, 64'hC100, 8'd1, 64'h3_0000, RESP_OKAY, wt);
        chk("t6_post_rst_latency", wt, 1);
        serve_write(0, 0, 64'hC200, 8'd0, 8'hF0, 0, 64'h4_0000, RESP_OKAY, wt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
